// File: rtl/period_meter.sv
// Measures the spacing between rising edges of a same-domain strobe, in clk cycles.
// Results go out over a valid/ready handshake; timeout and overrun are sticky.
module period_meter #(
  parameter int MAX_PERIOD        = 1000,
  parameter int NBITS_FOR_COUNTER = $clog2(MAX_PERIOD + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         tick_in,
  input  logic                         period_ready,
  input  logic                         clear_err,
  output logic [NBITS_FOR_COUNTER-1:0] period_out,
  output logic                         period_valid,
  output logic                         timeout,
  output logic                         overrun,
  output logic                         busy
);

  localparam int NB = NBITS_FOR_COUNTER;
  localparam logic [NB-1:0] MAX_CNT = NB'(MAX_PERIOD);
  localparam logic [NB-1:0] ONE     = NB'(1);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

  state_t        state_q, state_d;
  logic [NB-1:0] cnt_q, cnt_d;
  logic [NB-1:0] out_q, out_d;
  logic          tick_q;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic          overrun_q, overrun_d;

  logic tick_rise, res_vld, to_set, ov_set, xfer;

  assign tick_rise = tick_in & ~tick_q;
  assign xfer      = valid_q & period_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_vld = 1'b0;
    to_set  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          cnt_d = '0;
          if (tick_rise) begin
            cnt_d   = ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (tick_rise) begin
            res_vld = 1'b1;
            cnt_d   = ONE;
          end else if (cnt_q == MAX_CNT) begin
            // no edge within the window: give up on this period and re-arm
            to_set  = 1'b1;
            cnt_d   = '0;
            state_d = ARMED;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output slot: a fresh result loads only if the slot is empty or draining this cycle.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    ov_set  = 1'b0;
    if (res_vld && (!valid_q || xfer)) begin
      out_d   = cnt_q;
      valid_d = 1'b1;
    end else begin
      ov_set = res_vld;
      if (xfer) valid_d = 1'b0;
    end
    timeout_d = to_set | (timeout_q & ~clear_err);
    overrun_d = ov_set | (overrun_q & ~clear_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      out_q     <= '0;
      tick_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      tick_q    <= tick_in;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign period_out   = out_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q == MEASURE);

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: directed scenarios plus a random run, all against a
// time-stamp based reference model (period = now - time of previous edge).
module tb_period_meter;
  localparam int MAXP = 8;
  localparam int NB   = 4;

  logic          clk = 1'b0;
  logic          reset, enable, tick_in, period_ready, clear_err;
  logic [NB-1:0] period_out;
  logic          period_valid, timeout, overrun, busy;

  always #5 clk = ~clk;

  period_meter #(.MAX_PERIOD(MAXP), .NBITS_FOR_COUNTER(NB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .tick_in(tick_in),
    .period_ready(period_ready), .clear_err(clear_err),
    .period_out(period_out), .period_valid(period_valid),
    .timeout(timeout), .overrun(overrun), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // reference model
  typedef enum {M_IDLE, M_ARM, M_MEAS} mmode_t;
  mmode_t m_mode = M_IDLE;
  int     now = 0, t_last = 0, m_out = 0;
  bit     m_prev = 0, m_valid = 0, m_to = 0, m_ov = 0;

  // observation counters used by the directed scenarios
  int vcnt = 0, to_rise = 0;
  bit to_prev = 0;

  task automatic cyc(input bit rst, input bit en, input bit tk, input bit rdy, input bit clr);
    bit e, res, tset, xfer;
    int rv;
    @(negedge clk);
    reset = rst; enable = en; tick_in = tk; period_ready = rdy; clear_err = clr;
    e = tk && !m_prev;
    res = 0; tset = 0; rv = 0;
    if (rst) begin
      m_mode = M_IDLE; m_prev = 0; m_valid = 0; m_out = 0; m_to = 0; m_ov = 0;
    end else begin
      m_prev = tk;
      if (!en) m_mode = M_IDLE;
      else case (m_mode)
        M_IDLE: m_mode = M_ARM;
        M_ARM:  if (e) begin m_mode = M_MEAS; t_last = now; end
        M_MEAS: begin
          if (e) begin res = 1; rv = now - t_last; t_last = now; end
          else if (now - t_last == MAXP) begin tset = 1; m_mode = M_ARM; end
        end
        default: m_mode = M_IDLE;
      endcase
      xfer = m_valid && rdy;
      if (res && (!m_valid || xfer)) begin
        m_out = rv; m_valid = 1;
      end else begin
        if (res) m_ov = 1;
        else if (clr) m_ov = 0;
        if (xfer) m_valid = 0;
      end
      if (res && m_valid && !xfer && rv != m_out) m_ov = 1;
      if (!res && clr) m_ov = 0;
      m_to = tset ? 1'b1 : (clr ? 1'b0 : m_to);
    end
    now++;
    @(posedge clk); #1;
    chk("valid",   32'(period_valid), 32'(m_valid));
    chk("out",     32'(period_out),   32'(m_out));
    chk("timeout", 32'(timeout),      32'(m_to));
    chk("overrun", 32'(overrun),      32'(m_ov));
    chk("busy",    32'(busy),         32'(m_mode == M_MEAS));
    if (period_valid) vcnt++;
    if (timeout && !to_prev) to_rise++;
    to_prev = timeout;
  endtask

  task automatic pulse(input int gap, input bit rdy);
    cyc(0, 1, 1, rdy, 0);
    repeat (gap - 1) cyc(0, 1, 0, rdy, 0);
  endtask

  initial begin
    reset = 1; enable = 0; tick_in = 0; period_ready = 0; clear_err = 0;
    // reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1);
    chk("rst_valid", 32'(period_valid), 0);
    chk("rst_out",   32'(period_out),   0);
    chk("rst_busy",  32'(busy),         0);

    // steady ticks every 5 cycles
    cyc(0, 1, 0, 1, 0);
    repeat ($urandom_range(1, 3)) cyc(0, 1, 0, 1, 0);
    vcnt = 0;
    repeat (6) pulse(5, 1);
    chk("s1_vcnt", 32'(vcnt), 5);
    chk("s1_out",  32'(period_out), 5);
    chk("s1_to",   32'(timeout), 0);
    chk("s1_ov",   32'(overrun), 0);

    // period exactly MAXP measures; MAXP+1 times out and re-arms
    repeat (3) pulse(8, 1);
    chk("s2_out8", 32'(period_out), 8);
    chk("s2_to0",  32'(timeout), 0);
    pulse(9, 1);
    vcnt = 0;
    repeat (3) pulse(9, 1);
    chk("s2_vcnt", 32'(vcnt), 0);
    chk("s2_to1",  32'(timeout), 1);
    repeat (4) cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 1);
    chk("s2_clr",  32'(timeout), 0);

    // backpressure: held result, overrun, then load-on-transfer
    repeat (3) pulse(4, 0);
    chk("s3_ov",   32'(overrun), 1);
    chk("s3_out",  32'(period_out), 4);
    chk("s3_vld",  32'(period_valid), 1);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 0);
    chk("s3_vld2", 32'(period_valid), 1);
    chk("s3_out6", 32'(period_out), 6);
    chk("s3_ov0",  32'(overrun), 0);
    cyc(0, 1, 0, 1, 0);
    chk("s3_drain", 32'(period_valid), 0);

    // constant-high tick: one arm, one timeout, no results
    cyc(0, 0, 0, 1, 1);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    to_rise = 0; vcnt = 0;
    repeat (20) cyc(0, 1, 1, 1, 0);
    chk("s4_torise", 32'(to_rise), 1);
    chk("s4_vcnt",   32'(vcnt), 0);
    chk("s4_to",     32'(timeout), 1);
    cyc(0, 1, 0, 1, 1);

    // reset at counter=3 discards everything
    repeat (3) pulse(3, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("s5_vld",  32'(period_valid), 0);
    chk("s5_out",  32'(period_out), 0);
    chk("s5_to",   32'(timeout), 0);
    chk("s5_ov",   32'(overrun), 0);
    chk("s5_busy", 32'(busy), 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    vcnt = 0;
    repeat (2) pulse(6, 1);
    chk("s5_vcnt", 32'(vcnt), 1);
    chk("s5_out6", 32'(period_out), 6);

    // enable dropped with a result pending
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("s6_busy", 32'(busy), 0);
    chk("s6_vld",  32'(period_valid), 1);
    chk("s6_out",  32'(period_out), 6);
    cyc(0, 0, 0, 1, 0);
    chk("s6_xfer", 32'(period_valid), 0);

    // random run
    for (int i = 0; i < 1500; i++) begin
      bit rst, en, tk, rdy, clr;
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 49) != 0);
      tk  = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 15) == 0);
      cyc(rst, en, tk, rdy, clr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
